// File: rtl/csr_file_pkg.sv
// csr_file_pkg: CSR addresses, mstatus/mie bit positions and struct hookup types.
// Shared by csr_file and its counter sub-module.
// Optional counters are controlled by the CSR_COUNTERS_EN macro in csr_file.
package csr_file_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  // mstatus / mie / mip bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MSI      = 3;
  localparam int IRQ_MTI      = 7;
  localparam int IRQ_MEI      = 11;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  // Struct views of the top-level ports for struct-based hookup
  typedef struct packed {
    logic [11:0] raddr;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        exc;
    logic        intr;
    logic [3:0]  ecause;
    logic [31:0] epc;
    logic [31:0] etval;
    logic        mret;
    logic        retire;
    logic        meip;
    logic        mtip;
    logic        msip;
  } csr_file_in_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        illegal;
    logic        irq;
    logic [31:0] tvec;
    logic [31:0] mepc;
  } csr_file_out_type;

  // mtvec keeps only direct (00) or vectored (01) mode; 1x collapses to direct
  function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
    return {v[31:2], 1'b0, (v[1] ? 1'b0 : v[0])};
  endfunction

endpackage

// File: rtl/csr_file_counter.sv
// csr_counter: 64-bit counter with increment enable and per-half write enables.
// A write replaces the addressed half and suppresses the increment for that cycle.
// Carry from low to high word is applied in the same cycle; wraps at 2^64.
module csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Write has priority over increment; untouched half holds
  always_comb begin
    count_d = count_q;
    if (wen_lo || wen_hi) begin
      if (wen_lo) count_d[31:0]  = wdata;
      if (wen_hi) count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  // Counter state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) count_q <= 64'd0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR storage, trap entry/mret, irq decision, optional counters.
// Reads are combinational (zero latency); writes visible the cycle after wen, no bypass.
// Counters (mcycle/minstret + user aliases) exist only when CSR_COUNTERS_EN is defined.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HARTID = 32'd0,
  parameter logic [31:0] MISA   = 32'h4000_0100
) (
  input  logic        reset,
  input  logic        clock,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  output logic        illegal,
  input  logic        wen,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        exc,
  input  logic        intr,
  input  logic [3:0]  ecause,
  input  logic [31:0] epc,
  input  logic [31:0] etval,
  input  logic        mret,
  input  logic        retire,
  input  logic        meip,
  input  logic        mtip,
  input  logic        msip,
  output logic        irq,
  output logic [31:0] tvec,
  output logic [31:0] mepc_o
);

  logic        mie_bit_q, mie_bit_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [31:0] mstatus_rd;
  logic [31:0] mip_rd;
  logic        csr_we;
  logic [31:0] tvec_base;

  // A trap or mret in the same cycle discards the CSR write entirely
  assign csr_we     = wen & ~exc & ~mret;
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};
  assign mip_rd     = {20'd0, meip, 3'd0, mtip, 3'd0, msip, 3'd0};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;

  csr_counter u_mcycle (
    .clock  (clock),
    .reset  (reset),
    .inc    (1'b1),
    .wen_lo (csr_we && (waddr == CSR_MCYCLE)),
    .wen_hi (csr_we && (waddr == CSR_MCYCLEH)),
    .wdata  (wdata),
    .count  (mcycle)
  );

  csr_counter u_minstret (
    .clock  (clock),
    .reset  (reset),
    .inc    (retire),
    .wen_lo (csr_we && (waddr == CSR_MINSTRET)),
    .wen_hi (csr_we && (waddr == CSR_MINSTRETH)),
    .wdata  (wdata),
    .count  (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Combinational read decode; unimplemented addresses flag illegal and read 0
  always_comb begin
    rdata   = 32'd0;
    illegal = 1'b0;
    case (raddr)
      CSR_MSTATUS:  rdata = mstatus_rd;
      CSR_MISA:     rdata = MISA;
      CSR_MIE:      rdata = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP:      rdata = mip_rd;
      CSR_MHARTID:  rdata = HARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
`endif
      default:      illegal = 1'b1;
    endcase
  end

  // Next-state: trap entry beats mret beats a CSR write
  always_comb begin
    mie_bit_d  = mie_bit_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (exc) begin
      mepc_d    = {epc[31:2], 2'b00};
      mcause_d  = {intr, 27'd0, ecause};
      mtval_d   = etval;
      mpie_d    = mie_bit_q;
      mie_bit_d = 1'b0;
    end else if (mret) begin
      mie_bit_d = mpie_q;
      mpie_d    = 1'b1;
    end else if (csr_we) begin
      case (waddr)
        CSR_MSTATUS: begin
          mie_bit_d = wdata[MSTATUS_MIE];
          mpie_d    = wdata[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = wdata & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = legal_mtvec(wdata);
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        CSR_MTVAL:    mtval_d    = wdata;
        default: ;
      endcase
    end
  end

  // CSR state registers; reset overrides every other input
  always_ff @(posedge clock) begin
    if (reset) begin
      mie_bit_q  <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= 32'd0;
      mtvec_q    <= 32'd0;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mtval_q    <= 32'd0;
    end else begin
      mie_bit_q  <= mie_bit_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // Vectored mode offsets only interrupts by 4*cause; exceptions go to base
  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign tvec      = (mtvec_q[1:0] == 2'b01 && intr) ? tvec_base + {26'd0, ecause, 2'b00}
                                                     : tvec_base;
  assign irq       = mie_bit_q & (|(mip_rd & mie_q));
  assign mepc_o    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: table of write/read vectors plus
// hand-written trap, mret, priority, reset and (when compiled in) counter sequences.
module tb_csr_file;

  localparam logic [31:0] HID  = 32'd0;
  localparam logic [31:0] MISV = 32'h4000_0100;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        illegal;
  logic        wen;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        exc, intr, mret, retire, meip, mtip, msip;
  logic [3:0]  ecause;
  logic [31:0] epc, etval;
  logic        irq;
  logic [31:0] tvec, mepc_o;

  int total = 0;
  int bad   = 0;

  csr_file #(.HARTID(HID), .MISA(MISV)) dut (
    .reset(reset), .clock(clock), .raddr(raddr), .rdata(rdata), .illegal(illegal),
    .wen(wen), .waddr(waddr), .wdata(wdata), .exc(exc), .intr(intr), .ecause(ecause),
    .epc(epc), .etval(etval), .mret(mret), .retire(retire), .meip(meip), .mtip(mtip),
    .msip(msip), .irq(irq), .tvec(tvec), .mepc_o(mepc_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                              input logic [11:0] ra, input logic [31:0] er, input logic ei);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.exp_rd = er; v.exp_ill = ei;
    return v;
  endfunction

  initial begin
    // Reset-state reads first, then writes with legalisation and read-only checks
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'h300, 32'h0000_1800, 0));
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'h305, 32'h0,         0));
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'hF14, HID,           0));
    vecs.push_back(mk(1, 12'h305, 32'h8000_0101, 12'h305, 32'h8000_0101, 0));
    vecs.push_back(mk(1, 12'h305, 32'hFFFF_FFFE, 12'h305, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(1, 12'h305, 32'h1234_5673, 12'h305, 32'h1234_5670, 0));
    vecs.push_back(mk(1, 12'h305, 32'h8000_0101, 12'h305, 32'h8000_0101, 0));
    vecs.push_back(mk(1, 12'h341, 32'h8000_0047, 12'h341, 32'h8000_0044, 0));
    vecs.push_back(mk(1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 12'h301, 32'h0,         12'h301, MISV,          0));
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'h7C0, 32'h0,         1));
    vecs.push_back(mk(1, 12'h7C0, 32'h5555_5555, 12'h7C0, 32'h0,         1));
    vecs.push_back(mk(1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 0));
    vecs.push_back(mk(1, 12'h304, 32'h0000_0080, 12'h304, 32'h0000_0080, 0));
    vecs.push_back(mk(1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 0));
    vecs.push_back(mk(1, 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1808, 0));
    vecs.push_back(mk(1, 12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0,         0));
    vecs.push_back(mk(1, 12'h343, 32'hCAFE_F00D, 12'h343, 32'hCAFE_F00D, 0));
`ifdef CSR_COUNTERS_EN
    vecs.push_back(mk(1, 12'hB82, 32'h0000_0007, 12'hB82, 32'h0000_0007, 0));
    vecs.push_back(mk(1, 12'hC82, 32'h0000_0009, 12'hB82, 32'h0000_0007, 0));
`else
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'hB00, 32'h0,         1));
    vecs.push_back(mk(0, 12'h000, 32'h0,         12'hC02, 32'h0,         1));
`endif

    reset = 1; raddr = 12'h300; wen = 0; waddr = 0; wdata = 0;
    exc = 0; intr = 0; mret = 0; retire = 0; meip = 0; mtip = 0; msip = 0;
    ecause = 0; epc = 0; etval = 0;
    tick(); tick();
    reset = 0;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tvec", tvec, 32'd0);
    chk("rst_mepc", mepc_o, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      wen = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      tick();
      wen = 0;
      raddr = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
    end

    // mip reflects the level lines
    msip = 1; meip = 1;
    rd("mip_lines", 12'h344, 32'h0000_0808);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    msip = 0; meip = 0;

    // Timer interrupt with MIE=1, mie.MTIE=1
    mtip = 1;
    #1;
    chk("irq_mtip", {31'd0, irq}, 32'd1);

    // Interrupt trap in vectored mode
    exc = 1; intr = 1; ecause = 4'd7; epc = 32'h8000_0046; etval = 32'h1234_5678;
    #1;
    chk("tvec_vec_intr", tvec, 32'h8000_011C);
    tick();
    exc = 0; intr = 0; ecause = 0;
    chk("trap_mepc_o", mepc_o, 32'h8000_0044);
    rd("trap_mcause", 12'h342, 32'h8000_0007);
    rd("trap_mtval", 12'h343, 32'h1234_5678);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    chk("trap_irq_off", {31'd0, irq}, 32'd0);

    // mret together with a write: write is lost
    mret = 1; wen = 1; waddr = 12'h340; wdata = 32'h1111_1111;
    tick();
    mret = 0; wen = 0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    rd("mret_mscratch", 12'h340, 32'hDEAD_BEEF);
    chk("mret_irq_on", {31'd0, irq}, 32'd1);

    // Exception with a same-cycle mepc write: trap wins
    exc = 1; intr = 0; ecause = 4'd2; epc = 32'h0000_0103; etval = 32'h0;
    wen = 1; waddr = 12'h341; wdata = 32'h5555_5554;
    #1;
    chk("tvec_vec_exc", tvec, 32'h8000_0100);
    tick();
    exc = 0; wen = 0; ecause = 0;
    chk("exc_mepc_o", mepc_o, 32'h0000_0100);
    rd("exc_mcause", 12'h342, 32'h0000_0002);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);

    // Direct mode: intr does not offset the target
    wen = 1; waddr = 12'h305; wdata = 32'h0000_2000;
    tick();
    wen = 0; intr = 1; ecause = 4'd11;
    #1;
    chk("tvec_direct", tvec, 32'h0000_2000);
    intr = 0; ecause = 0;

    // Reset overrides a same-cycle trap
    reset = 1; exc = 1; intr = 1; ecause = 4'd3; epc = 32'hFFFF_FFF0;
    tick();
    reset = 0; exc = 0; intr = 0; ecause = 0;
    chk("rst2_mepc", mepc_o, 32'd0);
    chk("rst2_tvec", tvec, 32'd0);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mcause", 12'h342, 32'h0);
    mtip = 0;

`ifdef CSR_COUNTERS_EN
    // Low-word write, then high-word write, then carry on the free-running cycle
    wen = 1; waddr = 12'hB00; wdata = 32'hFFFF_FFFF;
    tick();
    waddr = 12'hB80; wdata = 32'h0;
    tick();
    wen = 0;
    rd("mcycle_held", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("cycleh_alias", 12'hC80, 32'h1);

    // minstret counts exactly the retire pulses
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      retire = (i % 2 == 0);
      tick();
    end
    retire = 0;
    tick();
    rd("minstret", 12'hB02, 32'd5);
    rd("instret_alias", 12'hC02, 32'd5);
    rd("minstreth", 12'hB82, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
